// File: rtl/rmt_action_pkg.sv
// Shared action-word definitions for the RMT stage: opcode encodings, the
// ALU operation selector they decode to, and the 2B bank flow-control states.
package rmt_action_pkg;

   localparam int OPCODE_W = 4;

   localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0001;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0010;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 4'b1001;
   localparam logic [OPCODE_W-1:0] OP_SUBI = 4'b1010;
   localparam logic [OPCODE_W-1:0] OP_SET  = 4'b1110;

   typedef enum logic [1:0] {
      ALU_A,
      ALU_ADD,
      ALU_SUB,
      ALU_B
   } alu_sel_e;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_OUT,
      ST_FULL
   } bank_state_e;

   // Immediate variants share the register datapath: the crossbar has already
   // placed the immediate on operand B.
   function automatic alu_sel_e decode_op(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_ADD, OP_ADDI: return ALU_ADD;
         OP_SUB, OP_SUBI: return ALU_SUB;
         OP_SET:          return ALU_B;
         default:         return ALU_A;
      endcase
   endfunction

endpackage

// File: rtl/alu_2b_lane.sv
// One 2-byte ALU lane: purely combinational, modulo-2^width_2B arithmetic,
// no flags and no saturation.
module alu_2b_lane
   import rmt_action_pkg::*;
#(
   parameter int width_2B = 16
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [width_2B-1:0] operand_a,
   input  logic [width_2B-1:0] operand_b,
   output logic [width_2B-1:0] result
);

   alu_sel_e w_sel;

   assign w_sel = decode_op(opcode);

   always_comb begin
      result = operand_a;
      case (w_sel)
         ALU_ADD: result = operand_a + operand_b;
         ALU_SUB: result = operand_a - operand_b;
         ALU_B:   result = operand_b;
         default: result = operand_a;
      endcase
   end

endmodule

// File: rtl/alu_2b_bank.sv
// Bank of NUM_PER_TYPE 2-byte ALU lanes with a one-entry output register plus
// one skid entry, so ready_out can be registered without dropping bundles.
module alu_2b_bank
   import rmt_action_pkg::*;
#(
   parameter int NUM_PER_TYPE = 8,
   parameter int ACT_LEN      = 25,
   parameter int width_2B     = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             alu_in_valid,
   input  logic [width_2B*NUM_PER_TYPE-1:0] alu_in_2B_1,
   input  logic [width_2B*NUM_PER_TYPE-1:0] alu_in_2B_2,
   input  logic [255:0]                     phv_remain_data,
   input  logic [ACT_LEN*25-1:0]            action_in,
   input  logic                             action_valid_in,
   output logic                             ready_out,
   output logic [width_2B*NUM_PER_TYPE-1:0] phv_2B_out,
   output logic [255:0]                     phv_remain_out,
   output logic                             phv_out_valid,
   input  logic                             ready_in,
   output logic [31:0]                      pkt_cnt,
   output logic                             err_valid_mismatch
);

   localparam int LANES_W = width_2B * NUM_PER_TYPE;

   logic [LANES_W-1:0] w_alu_result;
   logic               w_xfer;
   logic               w_load_out;
   logic               w_load_skid;
   logic               w_skid_to_out;
   logic               w_unused_action;
   bank_state_e        w_state_next;

   bank_state_e        r_state;
   logic               r_ready_out;
   logic               r_out_valid;
   logic [LANES_W-1:0] r_out_data;
   logic [255:0]       r_out_remain;
   logic [LANES_W-1:0] r_skid_data;
   logic [255:0]       r_skid_remain;
   logic [31:0]        r_pkt_cnt;
   logic               r_err;

   // Lane k reads the opcode nibble at the top of action slot k+1.
   generate
      for (genvar gi = 0; gi < NUM_PER_TYPE; gi++) begin : g_lane
         alu_2b_lane #(
            .width_2B (width_2B)
         ) u_lane (
            .opcode    (action_in[(gi+2)*ACT_LEN-1 -: OPCODE_W]),
            .operand_a (alu_in_2B_1[(gi+1)*width_2B-1 -: width_2B]),
            .operand_b (alu_in_2B_2[(gi+1)*width_2B-1 -: width_2B]),
            .result    (w_alu_result[(gi+1)*width_2B-1 -: width_2B])
         );
      end
   endgenerate

   // Only the lane opcode nibbles matter; the rest of the action word is for other units.
   assign w_unused_action = ^action_in;

   assign w_xfer = alu_in_valid && action_valid_in && r_ready_out;

   always_comb begin
      w_state_next  = r_state;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_xfer) begin
               w_load_out   = 1'b1;
               w_state_next = ST_OUT;
            end
         end
         ST_OUT: begin
            if (w_xfer && ready_in) begin
               w_load_out = 1'b1;
            end else if (w_xfer) begin
               w_load_skid  = 1'b1;
               w_state_next = ST_FULL;
            end else if (ready_in) begin
               w_state_next = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (ready_in) begin
               w_skid_to_out = 1'b1;
               w_state_next  = ST_OUT;
            end
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_ready_out <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_ready_out <= (w_state_next != ST_FULL);
         r_out_valid <= (w_state_next != ST_EMPTY);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data    <= '0;
         r_out_remain  <= '0;
         r_skid_data   <= '0;
         r_skid_remain <= '0;
      end else begin
         if (w_load_out) begin
            r_out_data   <= w_alu_result;
            r_out_remain <= phv_remain_data;
         end else if (w_skid_to_out) begin
            r_out_data   <= r_skid_data;
            r_out_remain <= r_skid_remain;
         end
         if (w_load_skid) begin
            r_skid_data   <= w_alu_result;
            r_skid_remain <= phv_remain_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
         end
         if (alu_in_valid != action_valid_in) begin
            r_err <= 1'b1;
         end
      end
   end

   assign ready_out          = r_ready_out;
   assign phv_out_valid      = r_out_valid;
   assign phv_2B_out         = r_out_data;
   assign phv_remain_out     = r_out_remain;
   assign pkt_cnt            = r_pkt_cnt;
   assign err_valid_mismatch = r_err;

endmodule

// File: tb/tb_alu_2b_bank.sv
// Self-checking bench for alu_2b_bank: directed scenarios plus a long random
// stream compared against a queue-based reference of held bundles.
module tb_alu_2b_bank;

   localparam int N  = 8;
   localparam int AL = 25;
   localparam int LW = 16 * N;
   localparam int AW = AL * 25;
   localparam int NUM_RAND = 10000;

   typedef struct {
      logic [LW-1:0]  a;
      logic [LW-1:0]  b;
      logic [255:0]   rem;
      logic [AW-1:0]  act;
   } bundle_t;

   typedef struct {
      logic [LW-1:0] res;
      logic [255:0]  rem;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          alu_in_valid;
   logic [LW-1:0] alu_in_2B_1;
   logic [LW-1:0] alu_in_2B_2;
   logic [255:0]  phv_remain_data;
   logic [AW-1:0] action_in;
   logic          action_valid_in;
   logic          ready_out;
   logic [LW-1:0] phv_2B_out;
   logic [255:0]  phv_remain_out;
   logic          phv_out_valid;
   logic          ready_in;
   logic [31:0]   pkt_cnt;
   logic          err_valid_mismatch;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_cnt;

   alu_2b_bank #(
      .NUM_PER_TYPE (N),
      .ACT_LEN      (AL),
      .width_2B     (16)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .alu_in_valid       (alu_in_valid),
      .alu_in_2B_1        (alu_in_2B_1),
      .alu_in_2B_2        (alu_in_2B_2),
      .phv_remain_data    (phv_remain_data),
      .action_in          (action_in),
      .action_valid_in    (action_valid_in),
      .ready_out          (ready_out),
      .phv_2B_out         (phv_2B_out),
      .phv_remain_out     (phv_remain_out),
      .phv_out_valid      (phv_out_valid),
      .ready_in           (ready_in),
      .pkt_cnt            (pkt_cnt),
      .err_valid_mismatch (err_valid_mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: lane k opcode is the top nibble of action slot k+1.
   function automatic logic [LW-1:0] ref_alu(input bundle_t bb);
      logic [LW-1:0] r;
      logic [15:0]   a;
      logic [15:0]   b;
      logic [3:0]    op;
      r = '0;
      for (int k = 0; k < N; k++) begin
         a  = bb.a[k*16 +: 16];
         b  = bb.b[k*16 +: 16];
         op = bb.act[(k+2)*AL-1 -: 4];
         case (op)
            4'd1, 4'd9:  r[k*16 +: 16] = a + b;
            4'd2, 4'd10: r[k*16 +: 16] = a - b;
            4'd14:       r[k*16 +: 16] = b;
            default:     r[k*16 +: 16] = a;
         endcase
      end
      return r;
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t     bb;
      logic [639:0] tmp;
      for (int i = 0; i < LW / 32; i++) begin
         bb.a[i*32 +: 32] = $urandom;
         bb.b[i*32 +: 32] = $urandom;
      end
      for (int i = 0; i < 8; i++) bb.rem[i*32 +: 32] = $urandom;
      for (int i = 0; i < 20; i++) tmp[i*32 +: 32] = $urandom;
      bb.act = tmp[AW-1:0];
      return bb;
   endfunction

   function automatic bundle_t zero_bundle();
      bundle_t bb;
      bb.a   = '0;
      bb.b   = '0;
      bb.rem = '0;
      bb.act = '0;
      return bb;
   endfunction

   task automatic drive(input bundle_t bb, input logic v_alu, input logic v_act, input logic rdy);
      alu_in_2B_1     = bb.a;
      alu_in_2B_2     = bb.b;
      phv_remain_data = bb.rem;
      action_in       = bb.act;
      alu_in_valid    = v_alu;
      action_valid_in = v_act;
      ready_in        = rdy;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(zero_bundle(), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 32'd0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (phv_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", phv_out_valid); end
      total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
      total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", pkt_cnt); end
      total++; if (err_valid_mismatch !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_valid_mismatch); end
      total++; if (phv_2B_out !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", phv_2B_out); end
      total++; if (phv_remain_out !== '0) begin bad++; $display("FAIL reset_remain got=%h exp=0", phv_remain_out); end
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 32'd0;
      @(posedge clk); #1;
      total++; if (phv_out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b exp=0", phv_out_valid); end
      $display("txn reset: valid=%b ready=%b cnt=%0d", phv_out_valid, ready_out, pkt_cnt);
   endtask

   task automatic test_add_sub();
      bundle_t bb;
      apply_reset();
      bb = zero_bundle();
      bb.act[2*AL-1 -: 4] = 4'b0001;
      bb.act[3*AL-1 -: 4] = 4'b0010;
      bb.a[15:0]  = 16'h0003;
      bb.b[15:0]  = 16'h0004;
      bb.a[31:16] = 16'h0000;
      bb.b[31:16] = 16'h0001;
      drive(bb, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      total++; if (phv_out_valid !== 1'b1) begin bad++; $display("FAIL addsub_valid got=%b exp=1", phv_out_valid); end
      total++; if (phv_2B_out[15:0] !== 16'h0007) begin bad++; $display("FAIL addsub_lane0 got=%h exp=0007", phv_2B_out[15:0]); end
      total++; if (phv_2B_out[31:16] !== 16'hFFFF) begin bad++; $display("FAIL addsub_lane1 got=%h exp=ffff", phv_2B_out[31:16]); end
      total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL addsub_cnt got=%0d exp=1", pkt_cnt); end
      $display("txn add_sub: lane0=%h lane1=%h", phv_2B_out[15:0], phv_2B_out[31:16]);
      @(negedge clk);
      drive(zero_bundle(), 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      total++; if (phv_out_valid !== 1'b0) begin bad++; $display("FAIL addsub_drain got=%b exp=0", phv_out_valid); end
   endtask

   task automatic test_set_default();
      bundle_t bb;
      apply_reset();
      bb = rand_bundle();
      bb.act[4*AL-1 -: 4] = 4'b1110;
      bb.act[5*AL-1 -: 4] = 4'b0000;
      bb.b[47:32] = 16'h1234;
      bb.a[63:48] = 16'hBEEF;
      drive(bb, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      total++; if (phv_2B_out[47:32] !== 16'h1234) begin bad++; $display("FAIL set_lane2 got=%h exp=1234", phv_2B_out[47:32]); end
      total++; if (phv_2B_out[63:48] !== 16'hBEEF) begin bad++; $display("FAIL default_lane3 got=%h exp=beef", phv_2B_out[63:48]); end
      total++; if (phv_remain_out !== bb.rem) begin bad++; $display("FAIL remain_pass got=%h exp=%h", phv_remain_out, bb.rem); end
      total++; if (phv_2B_out !== ref_alu(bb)) begin bad++; $display("FAIL set_all_lanes got=%h exp=%h", phv_2B_out, ref_alu(bb)); end
      $display("txn set_default: lane2=%h lane3=%h", phv_2B_out[47:32], phv_2B_out[63:48]);
      @(negedge clk);
      drive(zero_bundle(), 1'b0, 1'b0, 1'b1);
      @(posedge clk);
   endtask

   task automatic test_backpressure();
      bundle_t b1, b2, b3;
      apply_reset();
      b1 = rand_bundle(); b2 = rand_bundle(); b3 = rand_bundle();
      drive(b1, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      total++; if (phv_2B_out !== ref_alu(b1) || phv_out_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%h v=%b exp=%h", phv_2B_out, phv_out_valid, ref_alu(b1)); end
      total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", ready_out); end
      @(negedge clk);
      drive(b2, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%b exp=0", ready_out); end
      total++; if (phv_2B_out !== ref_alu(b1)) begin bad++; $display("FAIL bp_hold1 got=%h exp=%h", phv_2B_out, ref_alu(b1)); end
      @(negedge clk);
      drive(b3, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      total++; if (phv_2B_out !== ref_alu(b1) || phv_remain_out !== b1.rem) begin bad++; $display("FAIL bp_hold2 got=%h exp=%h", phv_2B_out, ref_alu(b1)); end
      total++; if (pkt_cnt !== 32'd2) begin bad++; $display("FAIL bp_cnt_full got=%0d exp=2", pkt_cnt); end
      $display("txn backpressure: held b1, ready_out=%b cnt=%0d", ready_out, pkt_cnt);
      @(negedge clk);
      drive(b3, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      total++; if (phv_2B_out !== ref_alu(b2) || phv_remain_out !== b2.rem) begin bad++; $display("FAIL bp_out2 got=%h exp=%h", phv_2B_out, ref_alu(b2)); end
      total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL bp_ready3 got=%b exp=1", ready_out); end
      $display("txn backpressure: out b2");
      @(negedge clk);
      drive(b3, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      total++; if (phv_2B_out !== ref_alu(b3) || phv_out_valid !== 1'b1) begin bad++; $display("FAIL bp_out3 got=%h v=%b exp=%h", phv_2B_out, phv_out_valid, ref_alu(b3)); end
      $display("txn backpressure: out b3");
      @(negedge clk);
      drive(zero_bundle(), 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      total++; if (phv_out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", phv_out_valid); end
      total++; if (pkt_cnt !== 32'd3) begin bad++; $display("FAIL bp_cnt got=%0d exp=3", pkt_cnt); end
   endtask

   task automatic test_mismatch();
      apply_reset();
      drive(rand_bundle(), 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      total++; if (err_valid_mismatch !== 1'b1) begin bad++; $display("FAIL mm_err got=%b exp=1", err_valid_mismatch); end
      total++; if (phv_out_valid !== 1'b0) begin bad++; $display("FAIL mm_valid got=%b exp=0", phv_out_valid); end
      total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL mm_cnt got=%0d exp=0", pkt_cnt); end
      $display("txn mismatch: err=%b cnt=%0d", err_valid_mismatch, pkt_cnt);
      @(negedge clk);
      drive(zero_bundle(), 1'b0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      total++; if (err_valid_mismatch !== 1'b1) begin bad++; $display("FAIL mm_sticky got=%b exp=1", err_valid_mismatch); end
      total++; if (phv_out_valid !== 1'b0) begin bad++; $display("FAIL mm_no_out got=%b exp=0", phv_out_valid); end
   endtask

   task automatic test_reset_in_full();
      apply_reset();
      drive(rand_bundle(), 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drive(rand_bundle(), 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL rf_full got=%b exp=0", ready_out); end
      @(negedge clk);
      rst_n = 1'b0;
      drive(zero_bundle(), 1'b0, 1'b0, 1'b1);
      #1;
      total++; if (phv_out_valid !== 1'b0 || ready_out !== 1'b1) begin bad++; $display("FAIL rf_async got v=%b r=%b exp v=0 r=1", phv_out_valid, ready_out); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (phv_out_valid !== 1'b0) begin bad++; $display("FAIL rf_valid got=%b exp=0", phv_out_valid); end
      total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL rf_ready got=%b exp=1", ready_out); end
      total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL rf_cnt got=%0d exp=0", pkt_cnt); end
      repeat (3) @(posedge clk);
      #1;
      total++; if (phv_out_valid !== 1'b0) begin bad++; $display("FAIL rf_no_ghost got=%b exp=0", phv_out_valid); end
      $display("txn reset_in_full: valid=%b ready=%b cnt=%0d", phv_out_valid, ready_out, pkt_cnt);
   endtask

   task automatic test_random();
      exp_t    eq[$];
      exp_t    e;
      bundle_t cur;
      logic    have_cur;
      logic    rdy;
      logic    m_ready;
      int      sent;
      int      popped;
      int      cycles;
      int      ready_pct;
      apply_reset();
      have_cur = 1'b0;
      sent     = 0;
      popped   = 0;
      cycles   = 0;
      cur      = zero_bundle();
      while ((sent < NUM_RAND || have_cur || eq.size() > 0) && cycles < 60000) begin
         cycles++;
         ready_pct = ((cycles / 500) % 2 == 0) ? 70 : 30;
         if (!have_cur && sent < NUM_RAND && $urandom_range(0, 99) < 75) begin
            cur      = rand_bundle();
            have_cur = 1'b1;
         end
         rdy = ($urandom_range(0, 99) < ready_pct);
         drive(cur, have_cur, have_cur, rdy);
         m_ready = (eq.size() < 2);
         @(posedge clk);
         if (eq.size() > 0 && rdy) begin
            e = eq.pop_front();
            popped++;
            $display("txn rand out %0d res=%h", popped, e.res);
         end
         if (have_cur && m_ready) begin
            e.res = ref_alu(cur);
            e.rem = cur.rem;
            eq.push_back(e);
            sent++;
            exp_cnt  = exp_cnt + 32'd1;
            have_cur = 1'b0;
         end
         #1;
         total++; if (phv_out_valid !== (eq.size() > 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cycles, phv_out_valid, eq.size() > 0); end
         total++; if (ready_out !== (eq.size() < 2)) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cycles, ready_out, eq.size() < 2); end
         total++; if (pkt_cnt !== exp_cnt) begin bad++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cycles, pkt_cnt, exp_cnt); end
         if (eq.size() > 0) begin
            total++; if (phv_2B_out !== eq[0].res) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cycles, phv_2B_out, eq[0].res); end
            total++; if (phv_remain_out !== eq[0].rem) begin bad++; $display("FAIL rand_remain cyc=%0d got=%h exp=%h", cycles, phv_remain_out, eq[0].rem); end
         end
         @(negedge clk);
      end
      total++; if (cycles >= 60000) begin bad++; $display("FAIL rand_timeout sent=%0d popped=%0d exp=%0d", sent, popped, NUM_RAND); end
      total++; if (popped != NUM_RAND) begin bad++; $display("FAIL rand_popped got=%0d exp=%0d", popped, NUM_RAND); end
      total++; if (err_valid_mismatch !== 1'b0) begin bad++; $display("FAIL rand_err got=%b exp=0", err_valid_mismatch); end
   endtask

   initial begin
      exp_cnt = 32'd0;
      rst_n   = 1'b1;
      drive(zero_bundle(), 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      test_reset();
      test_add_sub();
      test_set_default();
      test_backpressure();
      test_mismatch();
      test_reset_in_full();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
